mem_access_stage: RTL

Memory-stage access controller for the 5-stage pipelined MIPS core. Consumes the EX/MEM pipeline-register outputs, runs one load or store per instruction against the data-memory port using a req/ack handshake, and stalls the front of the pipeline until the access completes. It generates store byte-enables and aligned write data. It also extracts and sign- or zero-extends load data for the MEM/WB register.

---
 rtl/mem_access_stage.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM-stage load/store controller: one req/ack data-memory access per instruction, stall, lane steering.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and pulse misalign_o.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [1:0]  store_type_i,
    input  logic [2:0]  load_type_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic        stall_o,
    output logic [31:0] mem_rdata_o,
    output logic        bus_err_o,
    output logic        misalign_o
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, stateNext;

    logic [CW-1:0] waitCnt;
    logic [2:0]    loadType;
    logic [1:0]    laneAddr;

    logic        access, halfAcc, byteAcc, misalignNow, timeoutHit;
    logic [3:0]  beNext;
    logic [31:0] wdataNext, loadExt;
    logic [7:0]  selByte;
    logic [15:0] selHalf;

    assign access = mem_read_i | mem_write_i;

    // Access width comes from the store type for writes and the load type for reads.
    always_comb begin
        halfAcc = 1'b0;
        byteAcc = 1'b0;
        if (mem_write_i) begin
            halfAcc = (store_type_i == 2'b01);
            byteAcc = (store_type_i == 2'b10);
        end else begin
            halfAcc = load_type_i inside {3'b001, 3'b010};
            byteAcc = load_type_i inside {3'b011, 3'b100};
        end
    end

    always_comb begin
        beNext    = 4'b1111;
        wdataNext = wdata_i;
        if (byteAcc) begin
            beNext    = 4'b0001 << addr_i[1:0];
            wdataNext = {4{wdata_i[7:0]}};
        end else if (halfAcc) begin
            beNext    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdataNext = {2{wdata_i[15:0]}};
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalignNow = access &&
                         ((halfAcc && addr_i[0]) ||
                          (!halfAcc && !byteAcc && (addr_i[1:0] != 2'b00)));
`else
    assign misalignNow = 1'b0;
`endif

    // Fires on the last permitted BUSY cycle, giving exactly TIMEOUT-1 request cycles.
    assign timeoutHit = (waitCnt == CW'(TIMEOUT - 2));

    always_comb begin
        selByte = dmem_rdata_i[{laneAddr, 3'b000} +: 8];
        selHalf = laneAddr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (loadType)
            3'b001:  loadExt = {{16{selHalf[15]}}, selHalf};
            3'b010:  loadExt = {16'b0, selHalf};
            3'b011:  loadExt = {{24{selByte[7]}}, selByte};
            3'b100:  loadExt = {24'b0, selByte};
            default: loadExt = dmem_rdata_i;
        endcase
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (misalignNow) stateNext = DONE;
                     else if (access) stateNext = BUSY;
            BUSY:    if (dmem_ack_i || timeoutHit) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign stall_o = ((state == IDLE) && access) || (state == BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            mem_rdata_o  <= '0;
            bus_err_o    <= 1'b0;
            misalign_o   <= 1'b0;
            waitCnt      <= '0;
            loadType     <= '0;
            laneAddr     <= '0;
        end else begin
            state      <= stateNext;
            misalign_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (misalignNow) begin
                        misalign_o <= 1'b1;
                    end else if (access) begin
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= mem_write_i;
                        dmem_addr_o  <= {addr_i[31:2], 2'b00};
                        dmem_be_o    <= beNext;
                        dmem_wdata_o <= wdataNext;
                        loadType     <= load_type_i;
                        laneAddr     <= addr_i[1:0];
                        waitCnt      <= '0;
                    end
                end
                BUSY: begin
                    if (dmem_ack_i) begin
                        dmem_req_o <= 1'b0;
                        if (!dmem_we_o) mem_rdata_o <= loadExt;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                        if (timeoutHit) begin
                            dmem_req_o <= 1'b0;
                            bus_err_o  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
